// File: rtl/hamming_secded_dec_pkg.sv
// Shared types and constants for the (16,11) SECDED decode engine.
// Holds the FSM state type, the per-word flag codes, the default
// address map and the data-bit position map of the codeword.
package hamdec_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_LO,
      ST_RD_HI,
      ST_DEC,
      ST_WR_LO,
      ST_WR_HI,
      ST_DONE
   } hamdec_state_t;

   localparam logic [1:0] FLG_CLEAN = 2'b00;
   localparam logic [1:0] FLG_SEC   = 2'b01;
   localparam logic [1:0] FLG_DED   = 2'b10;

   localparam int DEF_SRC_BASE  = 64;
   localparam int DEF_DST_BASE  = 94;
   localparam int DEF_NUM_WORDS = 15;
   localparam int DEF_AW        = 8;

   // Hamming position of data bit d[k+1]: d1 at 3, d4..d2 at 7..5, d11..d5 at 15..9.
   function automatic logic [3:0] data_pos(input int k);
      if (k == 0)
         return 4'd3;
      else if (k < 4)
         return 4'(k + 4);
      else
         return 4'(k + 5);
   endfunction

endpackage

// File: rtl/hamming_secded_dec_if.sv
// Handshake and data-memory byte port of the SECDED decode engine.
// The slave modport is the engine; the master modport is the system side
// that raises start and returns combinational read data.
interface hamming_secded_dec_if
   import hamdec_pkg::*;
#(
   parameter int AW = DEF_AW
);
   logic          start;
   logic          halt;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rd_data;
   logic          mem_wr_en;
   logic [7:0]    mem_wr_data;
   logic [3:0]    sec_cnt;
   logic [3:0]    ded_cnt;

   modport master (
      output start, mem_rd_data,
      input  halt, mem_addr, mem_wr_en, mem_wr_data, sec_cnt, ded_cnt
   );

   modport slave (
      input  start, mem_rd_data,
      output halt, mem_addr, mem_wr_en, mem_wr_data, sec_cnt, ded_cnt
   );
endinterface

// File: rtl/hamming_secded_dec_dec16.sv
// Combinational (16,11) extended-Hamming decoder.
// Bit 0 is the overall parity; bits 1..15 are Hamming positions 1..15.
// A single error (odd overall parity) is corrected; a double error
// (even parity, nonzero syndrome) is reported and left uncorrected.
module secded_dec16
   import hamdec_pkg::*;
(
   input  logic [15:0] w_i,
   output logic [11:1] d_o,
   output logic [1:0]  flags_o,
   output logic        sec_o,
   output logic        ded_o
);
   logic [3:0] syn;
   logic       par;
   logic       fix;

   // Syndrome, overall parity and error classification.
   always_comb begin
      syn = 4'd0;
      for (int n = 1; n < 16; n++) begin
         if (w_i[n]) syn = syn ^ 4'(n);
      end
      par     = ^w_i;
      fix     = par && (syn != 4'd0);
      sec_o   = par;
      ded_o   = !par && (syn != 4'd0);
      flags_o = FLG_CLEAN;
      if (sec_o)
         flags_o = FLG_SEC;
      else if (ded_o)
         flags_o = FLG_DED;
   end

   // Data extraction; a data bit is inverted only when the syndrome points at it.
   always_comb begin
      d_o = '0;
      for (int k = 0; k < 11; k++) begin
         d_o[k+1] = w_i[data_pos(k)] ^ (fix && (syn == data_pos(k)));
      end
   end
endmodule

// File: rtl/hamming_secded_dec.sv
// SECDED decode engine: on start, reads NUM_WORDS encoded words as byte
// pairs from SRC_BASE, decodes them and writes 11-bit messages as byte
// pairs from DST_BASE, then holds halt high until the next start.
// Optional build macro HAMDEC_FLAGS_EN puts the per-word flags into
// bits [7:6] of each written high byte; otherwise those bits are zero.
module hamming_secded_dec
   import hamdec_pkg::*;
#(
   parameter int SRC_BASE  = DEF_SRC_BASE,
   parameter int DST_BASE  = DEF_DST_BASE,
   parameter int NUM_WORDS = DEF_NUM_WORDS,
   parameter int AW        = DEF_AW
)(
   input  logic               CLK,
   input  logic               reset,
   hamming_secded_dec_if.slave bus
);
   hamdec_state_t state_q, state_d;
   logic [3:0]    i_q, i_d;
   logic [15:0]   w_q, w_d;
   logic [11:1]   dat_q, dat_d;
   logic [3:0]    sec_q, sec_d;
   logic [3:0]    ded_q, ded_d;
   logic          halt_q;

   logic [11:1]   dec_dat;
   logic [1:0]    dec_flags;
   logic          dec_sec;
   logic          dec_ded;
   logic [1:0]    flag_out;

   logic [AW-1:0] src_lo;
   logic [AW-1:0] dst_lo;
   logic [AW-1:0] addr;
   logic          wr_en;
   logic [7:0]    wr_data;

   secded_dec16 u_dec (
      .w_i     (w_q),
      .d_o     (dec_dat),
      .flags_o (dec_flags),
      .sec_o   (dec_sec),
      .ded_o   (dec_ded)
   );

   assign src_lo = AW'(SRC_BASE) + AW'({i_q, 1'b0});
   assign dst_lo = AW'(DST_BASE) + AW'({i_q, 1'b0});

`ifdef HAMDEC_FLAGS_EN
   logic [1:0] flg_q, flg_d;
   assign flag_out = flg_q;
`else
   logic [1:0] unused_flags;
   assign unused_flags = dec_flags;
   assign flag_out     = FLG_CLEAN;
`endif

   // Next-state, datapath updates and memory-port outputs.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      w_d     = w_q;
      dat_d   = dat_q;
      sec_d   = sec_q;
      ded_d   = ded_q;
`ifdef HAMDEC_FLAGS_EN
      flg_d   = flg_q;
`endif
      addr    = '0;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d = ST_RD_LO;
               i_d     = 4'd0;
               sec_d   = 4'd0;
               ded_d   = 4'd0;
            end
         end
         ST_RD_LO: begin
            addr       = src_lo;
            w_d[7:0]   = bus.mem_rd_data;
            state_d    = ST_RD_HI;
         end
         ST_RD_HI: begin
            addr       = src_lo + AW'(1);
            w_d[15:8]  = bus.mem_rd_data;
            state_d    = ST_DEC;
         end
         ST_DEC: begin
            dat_d = dec_dat;
`ifdef HAMDEC_FLAGS_EN
            flg_d = dec_flags;
`endif
            if (dec_sec) sec_d = sec_q + 4'd1;
            if (dec_ded) ded_d = ded_q + 4'd1;
            state_d = ST_WR_LO;
         end
         ST_WR_LO: begin
            addr    = dst_lo;
            wr_en   = 1'b1;
            wr_data = dat_q[8:1];
            state_d = ST_WR_HI;
         end
         ST_WR_HI: begin
            addr    = dst_lo + AW'(1);
            wr_en   = 1'b1;
            wr_data = {flag_out, 3'b000, dat_q[11:9]};
            if (i_q == 4'(NUM_WORDS - 1)) begin
               state_d = ST_DONE;
            end else begin
               i_d     = i_q + 4'd1;
               state_d = ST_RD_LO;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; halt is high exactly while in DONE.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         w_q     <= '0;
         dat_q   <= '0;
         sec_q   <= '0;
         ded_q   <= '0;
         halt_q  <= 1'b0;
`ifdef HAMDEC_FLAGS_EN
         flg_q   <= FLG_CLEAN;
`endif
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         w_q     <= w_d;
         dat_q   <= dat_d;
         sec_q   <= sec_d;
         ded_q   <= ded_d;
         halt_q  <= (state_d == ST_DONE);
`ifdef HAMDEC_FLAGS_EN
         flg_q   <= flg_d;
`endif
      end
   end

   assign bus.halt        = halt_q;
   assign bus.mem_addr    = addr;
   assign bus.mem_wr_en   = wr_en;
   assign bus.mem_wr_data = wr_data;
   assign bus.sec_cnt     = sec_q;
   assign bus.ded_cnt     = ded_q;
endmodule
